// File: rtl/bcd_display_scanner_pkg.sv
// Shared types and constants for the BCD display scanner.
// Segment patterns are active-high in {g,f,e,d,c,b,a} order; any
// display polarity inversion happens later, in the top level.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Bundle of digit inputs and display drive outputs for the scanner.
// The slave side is the scanner itself; the master side feeds it digits
// and watches the display lines.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    lzb_en;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_start;
  logic                    code_err;

  modport master (
    output enable, digits_in, lzb_en,
    input  seg, digit_sel, frame_start, code_err
  );

  modport slave (
    input  enable, digits_in, lzb_en,
    output seg, digit_sel, frame_start, code_err
  );

endinterface

// File: rtl/bcd_display_scanner_bcd_to_seg.sv
// Combinational BCD to 7-segment decoder (active-high gfedcba).
// Codes above 9 show a single dash and raise the invalid flag.
module bcd_to_seg
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] code_i,
  output logic [6:0]       seg_o,
  output logic             invalid_o
);

  // Table lookup; anything outside 0..9 becomes the dash.
  always_comb begin
    seg_o     = SEG_DASH;
    invalid_o = 1'b0;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: begin
        seg_o     = SEG_DASH;
        invalid_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed scanner for NUM_DIGITS BCD digits onto one
// common-segment display. Digits are snapshotted once per frame so a
// changing counter never tears the picture mid-scan. Display outputs are
// registered one cycle behind state/idx, which gives a blank gap after
// every LOAD to avoid ghosting between frames.
module bcd_display_scanner
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bcd_display_scanner_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(PRESCALE - 1);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  state_e                  state_q, state_d;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;

  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    err_q, err_d;

  logic [BCD_W-1:0]        curCode;
  logic                    curLzb;
  logic [NUM_DIGITS-1:0]   lzbMask;
  logic [NUM_DIGITS-1:0]   selOneHot;
  logic                    allZero;
  logic [6:0]              rawSeg;
  logic                    rawInvalid;
  logic [6:0]              segActive;
  logic                    tick;

  assign tick = (presc_q == LAST_PRE);

  // Frame sequencer: IDLE waits for enable, LOAD grabs the digits, SCAN
  // walks idx 0..N-1 holding each for PRESCALE cycles; dropping enable
  // wins over everything else.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        idx_d   = '0;
        if (bus.enable) state_d = LOAD;
      end
      LOAD: begin
        snap_d  = bus.digits_in;
        presc_d = '0;
        idx_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (tick) begin
          presc_d = '0;
          if (idx_q == LAST_IDX) state_d = LOAD;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!bus.enable) state_d = IDLE;
  end

  // Leading-zero mask: digit i is blankable when it and all higher digits
  // of the snapshot are zero; digit 0 is never part of the mask.
  always_comb begin
    allZero = 1'b1;
    lzbMask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      allZero    = allZero & (snap_q[4*i +: 4] == 4'd0);
      lzbMask[i] = allZero;
    end
  end

  // Pick the digit under the scan pointer and build its one-hot select.
  always_comb begin
    curCode   = '0;
    curLzb    = 1'b0;
    selOneHot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        curCode      = snap_q[4*i +: 4];
        curLzb       = lzbMask[i];
        selOneHot[i] = 1'b1;
      end
    end
  end

  bcd_to_seg u_dec (
    .code_i   (curCode),
    .seg_o    (rawSeg),
    .invalid_o(rawInvalid)
  );

  // Display drive for the next cycle; blank unless actively scanning.
  always_comb begin
    segActive = (bus.lzb_en && curLzb) ? SEG_BLANK : rawSeg;
    seg_d     = SEG_OFF;
    sel_d     = SEL_OFF;
    err_d     = 1'b0;
    if (state_q == SCAN) begin
      seg_d = SEG_ACTIVE_LOW ? ~segActive : segActive;
      sel_d = DIG_ACTIVE_LOW ? ~selOneHot : selOneHot;
      err_d = rawInvalid;
    end
  end

  // State, counters, snapshot and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      seg_q   <= SEG_OFF;
      sel_q   <= SEL_OFF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.digit_sel   = sel_q;
  assign bus.code_err    = err_q;
  assign bus.frame_start = (state_q == LOAD);

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Downstream consumer of the BCD counter stage. It takes NUM_DIGITS packed BCD digits, one per counter instance, and time-multiplexes them onto one common-segment 7-segment display with per-digit select lines. It includes a refresh prescaler, a per-frame snapshot of the input digits, optional leading-zero blanking, and a dash for illegal codes 10–15. Code 4'b1111 is the counter's error output.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal range 2..8; digit 0 is least significant.
PRESCALE, 1000, clk cycles each digit is held; legal range >=2.
SEG_ACTIVE_LOW, 1, 1 inverts seg so 0 means lit; 0 makes seg active-high.
DIG_ACTIVE_LOW, 1, 1 drives the selected digit_sel bit to 0 and all others to 1; 0 is the one-hot high form.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
enable  in  1  scan enable; 0 means the display is blanked.
digits_in  in  4*NUM_DIGITS  packed BCD; digit i sits at bits [4i+3:4i].
lzb_en  in  1  leading-zero blanking enable.
seg  out  7  segment drive, bit order {g,f,e,d,c,b,a}.
digit_sel  out  NUM_DIGITS  digit select.
frame_start  out  1  one-cycle pulse in the LOAD state.
code_err  out  1  high while the digit being displayed holds a code >9.

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE; prescaler=0; idx=0; snapshot=0.
  - seg=blank (7'h7F if SEG_ACTIVE_LOW, else 7'h00).
  - digit_sel=all-off; frame_start=0; code_err=0.
- FSM states: IDLE, LOAD, SCAN.
  - IDLE: enable=1 -> LOAD.
  - LOAD: lasts exactly one cycle. Captures digits_in into snapshot, clears idx and prescaler, then -> SCAN.
  - SCAN: prescaler increments each cycle. At PRESCALE-1 it produces a tick and wraps to 0.
    - On tick with idx<NUM_DIGITS-1: idx increments.
    - On tick with idx==NUM_DIGITS-1: -> LOAD.
  - enable=0 in any state -> IDLE at the next edge. This overrides the tick.
- Frame period = 1 + NUM_DIGITS*PRESCALE cycles. Digit order is 0,1,..,N-1.
- frame_start = (state==LOAD), decoded from the state register.
- seg, digit_sel and code_err are registered and lag state/idx by exactly one cycle.
  - They are blank/all-off/0 in the cycle after IDLE or LOAD, which gives a one-cycle anti-ghost gap per frame.
- Decode (active-high gfedcba):
  - Digits 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F.
  - Codes 10..15 = 40 (dash, segment g), with code_err=1.
  - The polarity inversion is applied after decode.
- Leading-zero blanking (lzb_en=1):
  - Digit i>0 shows blank segments if it and every more-significant digit are 0.
  - digit_sel is still driven for that digit.
  - Digit 0 is never blanked.
  - Invalid codes count as non-zero.
- lzb_en is sampled every cycle. Changes to digits_in take effect only at the next LOAD, so there is no mid-frame tearing.
- Reset mid-scan returns everything to reset values immediately. The first frame after release starts with LOAD one cycle after enable=1 is sampled.

Decomposition:
- Package bcd_pkg holds:
  - The state enum (IDLE, LOAD, SCAN).
  - The 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK (active-high).
  - The BCD digit width constant 4.
- One combinational sub-module bcd_to_seg: 4-bit code in; 7-bit active-high segments and an invalid flag out.
- The top-level block owns the prescaler, FSM, snapshot, LZB logic, polarity and output registers.

Test Plan:
(All scenarios use NUM_DIGITS=4, PRESCALE=4 and active-low polarity; frame = 17 cycles.)
1. Reset: hold reset_n=0 with enable=1 -> seg=7'h7F, digit_sel=4'hF, frame_start=0, code_err=0; release -> frame_start pulses on the next cycle.
2. digits_in=16'h1234, lzb_en=0 -> after the one blank cycle, each line holds 4 cycles:
   - digit_sel=E with seg=19.
   - digit_sel=D with seg=30.
   - digit_sel=B with seg=24.
   - digit_sel=7 with seg=79.
   - Then one blank cycle; frame_start repeats every 17 cycles.
3. digits_in=16'h0050, lzb_en=1 -> idx0 seg=40, idx1 seg=12, idx2 and idx3 seg=7F with their digit_sel still low.
   - With 16'h0000: only idx0 lit (40).
4. digits_in=16'h00A9 -> idx0 seg=10; idx1 seg=3F with code_err=1 for exactly those 4 cycles; code_err=0 elsewhere.
5. Change digits_in from 16'h1234 to 16'h5678 during idx1 -> remaining digits still show 2,1; the new values appear only after the next frame_start.
6. Drop enable during idx2 -> state goes IDLE on the next edge and outputs go blank one cycle later; re-assert -> LOAD, and scanning restarts at idx0.
   - Also assert reset_n low mid-SCAN -> outputs go blank asynchronously.
